// File: rtl/down_counters_pkg.sv
// Shared constants and state encoding for the loadable down counter/timer.
package down_counters_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counters.sv
// Loadable N-bit down counter/timer with terminal-count pulse and optional
// auto-reload; all outputs registered.
module down_counters
  import down_counters_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  output logic [N-1:0] Q,
  output logic         busy,
  output logic         done,
  output logic         tc
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic [N-1:0] r_q;
  logic [N-1:0] r_reload;
  logic         r_busy;
  logic         r_done;
  logic         r_tc;

  // busy/done are updated alongside every state assignment so they stay
  // registered copies of the state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_reload <= load_value;
        r_q      <= load_value;
        r_state  <= IDLE;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (r_q != '0) begin
                r_state <= RUN;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
              end else if (r_reload != '0) begin
                r_q     <= r_reload;
                r_state <= RUN;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
              end
            end
          end
          RUN: begin
            if (stop) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b0;
            end else if (r_q > ONE) begin
              r_q <= r_q - ONE;
            end else if (r_q == ONE) begin
              r_q  <= '0;
              r_tc <= 1'b1;
              if (!auto_reload) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              // Sitting at zero while running only happens in periodic mode.
              r_q <= r_reload;
            end
          end
          DONE: begin
            if (start && (r_reload != '0)) begin
              r_q     <= r_reload;
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q    = r_q;
  assign busy = r_busy;
  assign done = r_done;
  assign tc   = r_tc;

endmodule

// File: tb/tb_down_counters.sv
// Directed self-checking bench for down_counters (N=8).
module tb_down_counters;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] Q;
  logic       busy, done, tc;

  int n_checks = 0;
  int n_pass   = 0;

  down_counters #(.N(8)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .Q(Q), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ld, input logic st, input logic sp, input logic [7:0] v);
    load = ld; start = st; stop = sp; load_value = v;
    tick();
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int q, input int b, input int d, input int t);
    chk({tag, ".Q"}, Q, q);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
    chk({tag, ".tc"}, tc, t);
  endtask

  int aq[8]  = '{2, 1, 0, 3, 2, 1, 0, 3};
  int atc[8] = '{0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    tick();
    chk_all("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // reset mid-count
    pulse(1, 0, 0, 8'd10);
    pulse(0, 1, 0, 8'd0);
    chk_all("rst_start", 10, 1, 0, 0);
    repeat (3) tick();
    chk("rst_cnt.Q", Q, 7);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all("rst_mid", 0, 0, 0, 0);

    // one-shot V=5
    pulse(1, 0, 0, 8'd5);
    chk_all("os_load", 5, 0, 0, 0);
    pulse(0, 1, 0, 8'd0);
    chk_all("os_start", 5, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all("os_run", 5 - i, 1, 0, 0);
    end
    tick();
    chk_all("os_tc", 0, 0, 1, 1);
    tick();
    chk_all("os_hold1", 0, 0, 1, 0);
    tick();
    chk_all("os_hold2", 0, 0, 1, 0);

    // restart from DONE with V=4
    pulse(1, 0, 0, 8'd4);
    pulse(0, 1, 0, 8'd0);
    repeat (4) tick();
    chk_all("rd_done", 0, 0, 1, 1);
    pulse(0, 1, 0, 8'd0);
    chk_all("rd_restart", 4, 1, 0, 0);
    tick();
    chk("rd_dec.Q", Q, 3);

    // auto-reload V=3
    auto_reload = 1'b1;
    pulse(1, 0, 0, 8'd3);
    pulse(0, 1, 0, 8'd0);
    chk_all("ar_start", 3, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("ar_seq", aq[i], 1, 0, atc[i]);
    end
    auto_reload = 1'b0;
    tick(); chk("ar_off2.Q", Q, 2);
    tick(); chk("ar_off1.Q", Q, 1);
    tick(); chk_all("ar_end", 0, 0, 1, 1);
    tick(); chk_all("ar_hold", 0, 0, 1, 0);

    // pause / resume from 5
    pulse(1, 0, 0, 8'd8);
    pulse(0, 1, 0, 8'd0);
    repeat (3) tick();
    chk("pr_at5.Q", Q, 5);
    pulse(0, 0, 1, 8'd0);
    chk_all("pr_stop", 5, 0, 0, 0);
    tick();
    chk_all("pr_frozen", 5, 0, 0, 0);
    pulse(0, 1, 0, 8'd0);
    chk_all("pr_resume", 5, 1, 0, 0);
    repeat (4) tick();
    chk_all("pr_at1", 1, 1, 0, 0);
    tick();
    chk_all("pr_zero", 0, 0, 1, 1);

    // load beats start; load of zero makes start a no-op
    pulse(1, 1, 0, 8'd7);
    chk_all("ls_same", 7, 0, 0, 0);
    tick();
    chk_all("ls_hold", 7, 0, 0, 0);
    pulse(1, 0, 0, 8'd0);
    pulse(0, 1, 0, 8'd0);
    chk_all("zero_start", 0, 0, 0, 0);
    tick();
    chk_all("zero_hold", 0, 0, 0, 0);

    // start+stop together: stop wins in RUN, start wins in IDLE
    pulse(1, 0, 0, 8'd6);
    pulse(0, 1, 0, 8'd0);
    tick();
    chk("ss_run.Q", Q, 5);
    pulse(0, 1, 1, 8'd0);
    chk_all("ss_in_run", 5, 0, 0, 0);
    pulse(0, 1, 1, 8'd0);
    chk_all("ss_in_idle", 5, 1, 0, 0);
    tick();
    chk("ss_dec.Q", Q, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/down_counters.md
# down_counters

Loadable N-bit down counter/timer that counts from a programmed value to zero, flags the terminal count, and optionally auto-reloads for periodic operation. It complements `up_counters` in the counters library: `up_counters` counts up from reset, while `down_counters` counts down from a loaded value. It serves as the timeout, delay and periodic-tick source for other blocks in the design. All outputs are registered.

## Interface
Parameters:
- `N`, 8, counter and load-value width in bits (N ≥ 2)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load`  in  1  load strobe, one cycle
- `load_value`  in  N  value captured on `load`
- `start`  in  1  start/resume strobe, one cycle
- `stop`  in  1  pause strobe, one cycle
- `auto_reload`  in  1  level; 1 = periodic mode
- `Q`  out  N  current count
- `busy`  out  1  high while counting (state RUN)
- `done`  out  1  high in state DONE (one-shot finished)
- `tc`  out  1  one-cycle terminal-count pulse

## Operation
- Internal registers: `Q`, `reload_reg` (N bits), and a state register with states IDLE, RUN and DONE.
- Reset (`reset`=1 at an edge): `Q`=0, `reload_reg`=0, state=IDLE, `busy`=0, `done`=0, `tc`=0. Reset overrides every other input, including mid-count.
- Priority per edge is reset > load > stop > start > count.
- load (any state): `reload_reg`←`load_value`, `Q`←`load_value`, state→IDLE, `tc`=0. A count in progress is aborted.
- start in IDLE:
  - If `Q`≠0, state→RUN and counting resumes from `Q`.
  - Else if `reload_reg`≠0, `Q`←`reload_reg` and state→RUN.
  - Otherwise start is ignored.
- start in DONE: if `reload_reg`≠0, `Q`←`reload_reg` and state→RUN; otherwise ignored. start in RUN is ignored.
- stop in RUN: state→IDLE and `Q` holds its value. stop in IDLE or DONE is ignored. If start and stop are asserted together, only the rule for the current state applies.
- RUN, `Q`>1: `Q`←`Q`−1.
- RUN, `Q`=1: `Q`←0 and `tc`←1.
  - If `auto_reload`=0 at this edge, state→DONE.
  - If `auto_reload`=1, state stays RUN.
- RUN, `Q`=0 (auto-reload mode only): `Q`←`reload_reg`. Period is `reload_reg`+1 cycles. Deasserting `auto_reload` takes effect at the next 1→0 transition.
- `Q` never wraps below 0 and never decrements from 0.
- `busy` = (state==RUN) and `done` = (state==DONE), both registered with the state.

## Timing
- All outputs change only on rising edges of `clk`. There is no combinational path from any input to any output.
- load at edge k: `Q`=`load_value` is visible after edge k.
- start at edge k: `busy`=1 after edge k, and the first decrement happens at edge k+1.
- One-shot with loaded value V≥1 and start at edge k:
  - `Q`=0, `tc`=1, `done`=1 and `busy`=0 after edge k+V.
  - `tc` returns to 0 after edge k+V+1.
- Auto-reload with V: `tc` pulses every V+1 cycles, and `Q` runs V…1,0,V…
- stop at edge k: `Q` is frozen from edge k onward. A later start at edge m resumes the decrement at edge m+1.

## Structure
- Shared package/header `down_counters_pkg`: state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2. The default width constant is also defined there.
- Single module with no sub-module. The design is one state register plus count and reload datapaths.
- The unused state encoding 2'd3 recovers to IDLE.

## Test plan
- Reset mid-count: load 10, start, apply `reset` after 3 cycles → `Q`=0, `busy`=0, `done`=0, `tc`=0 on the next edge.
- One-shot: load 5, start at edge k → `Q` runs 5,4,3,2,1,0. `tc`=1 and `done`=1 after edge k+5. `Q` holds 0 with no further `tc`.
- Auto-reload: load 3, `auto_reload`=1, start → `Q` runs 3,2,1,0,3,2,1,0 and `tc` pulses every 4 cycles. Clearing `auto_reload` ends in DONE at the next 0.
- Pause/resume: load 8, start, stop when `Q`=5 → `Q` holds 5 and `busy`=0. start → `Q` reaches 0 exactly 5 cycles later.
- Load priority and zero: load and start in the same cycle with `load_value`=7 → state IDLE, `Q`=7. load 0 then start → ignored, `busy`=0, no `tc`.
- Restart from DONE: after a one-shot of V=4, start → `Q`=4 and `busy`=1 after the start edge, and `done` clears.
